// File: rtl/bit_plotter_trigger_pkg.sv
// Shared definitions for the bit plotter trigger front-end: FSM state
// encoding, trigger mode codes and the trigger-match helper.
package bit_plotter_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [1:0] MODE_IMM  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_ANY  = 2'b11;

    // True when the synchronized probe edges satisfy the latched trigger mode.
    function automatic logic trigger_hit(input logic [1:0] m,
                                         input logic       rise,
                                         input logic       fall);
        logic hit;
        case (m)
            MODE_IMM:  hit = 1'b1;
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_ANY:  hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/bit_plotter_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// single-cycle press pulse on the debounced 0->1 transition.
module bit_plotter_debouncer
    import bit_plotter_trigger_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rawIn,
    output logic level,
    output logic pressEvent
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

    logic                     sync1;
    logic                     sync2;
    logic [DEBOUNCE_BITS-1:0] count;

    // Synchronize the button and accept a new level only after it has been
    // stable for the full counter range; a release produces no event.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            count      <= '0;
            pressEvent <= 1'b0;
        end else begin
            sync1      <= rawIn;
            sync2      <= sync1;
            pressEvent <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == '1) begin
                level      <= sync2;
                count      <= '0;
                pressEvent <= sync2;
            end else begin
                count <= count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/bit_plotter_trigger.sv
// Bit plotter front-end: probe synchronizer, button debouncers and the
// arm/trigger FSM that drives the plotter's start/clear/bitIn.
module bit_plotter_trigger
    import bit_plotter_trigger_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int CAPTURE_BITS  = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       probeIn,
    input  logic       armButton,
    input  logic       clearButton,
    input  logic [1:0] mode,
    input  logic       autoRearm,
    output logic       bitOut,
    output logic       start,
    output logic       clear,
    output logic       armed,
    output logic       capturing
);

    localparam logic [CAPTURE_BITS-1:0] CAP_ONE = {{(CAPTURE_BITS-1){1'b0}}, 1'b1};

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fall;

    logic armEvt;
    logic clearEvt;
    logic armLevel_unused;
    logic clearLevel_unused;

    state_t                  state;
    logic [1:0]              modeReg;
    logic [CAPTURE_BITS-1:0] capCount;

    // Probe synchronizer; the third stage only exists for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= probeIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign bitOut = s2;
    assign rise   = s2 & ~s3;
    assign fall   = ~s2 & s3;

    bit_plotter_debouncer #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_arm_db (
        .clk       (clk),
        .reset     (reset),
        .rawIn     (armButton),
        .level     (armLevel_unused),
        .pressEvent(armEvt)
    );

    bit_plotter_debouncer #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_clear_db (
        .clk       (clk),
        .reset     (reset),
        .rawIn     (clearButton),
        .level     (clearLevel_unused),
        .pressEvent(clearEvt)
    );

    // Arm/trigger FSM with capture counter; clear beats arm beats trigger
    // beats window end. The trigger is only looked at once the state is
    // already ARMED, so an edge in the arming cycle cannot fire it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            modeReg   <= MODE_IMM;
            capCount  <= '0;
            start     <= 1'b0;
            clear     <= 1'b0;
            armed     <= 1'b0;
            capturing <= 1'b0;
        end else begin
            start <= 1'b0;
            clear <= 1'b0;
            if (clearEvt) begin
                clear     <= 1'b1;
                state     <= IDLE;
                armed     <= 1'b0;
                capturing <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (armEvt) begin
                            clear   <= 1'b1;
                            modeReg <= mode;
                            state   <= ARMED;
                            armed   <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (trigger_hit(modeReg, rise, fall)) begin
                            start     <= 1'b1;
                            capCount  <= '0;
                            state     <= CAPTURING;
                            armed     <= 1'b0;
                            capturing <= 1'b1;
                        end
                    end
                    CAPTURING: begin
                        if (capCount == '1) begin
                            capturing <= 1'b0;
                            if (autoRearm) begin
                                clear   <= 1'b1;
                                modeReg <= mode;
                                state   <= ARMED;
                                armed   <= 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            capCount <= capCount + CAP_ONE;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        armed     <= 1'b0;
                        capturing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
